// File: rtl/ram_lsu_pkg.sv
// Shared types for the load/store unit: access sizes, FSM states, data width.
package ram_lsu_pkg;

   localparam int unsigned WORD_W = 32;

   // Encoding of req_size_i; 2'd3 is illegal and raises an access error.
   typedef enum logic [1:0] {
      SIZE_B = 2'd0,
      SIZE_H = 2'd1,
      SIZE_W = 2'd2
   } size_e;

   typedef enum logic [1:0] {
      StIdle,
      StRead,
      StWrite,
      StResp
   } state_e;

endpackage

// File: rtl/ram_lsu_lane.sv
// Combinational lane logic: load-side extract/extend and store-side lane merge.
module ram_lsu_lane
   import ram_lsu_pkg::*;
(
   input  logic [1:0]        size_i,
   input  logic              unsigned_i,
   input  logic [1:0]        lane_i,
   input  logic [WORD_W-1:0] load_word_i,
   input  logic [WORD_W-1:0] store_base_i,
   input  logic [WORD_W-1:0] store_data_i,
   output logic [WORD_W-1:0] load_data_o,
   output logic [WORD_W-1:0] store_word_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Pick the addressed lane of the read word and sign/zero-extend it.
   always_comb begin
      byte_sel = load_word_i[7:0];
      unique case (lane_i)
         2'd0: byte_sel = load_word_i[7:0];
         2'd1: byte_sel = load_word_i[15:8];
         2'd2: byte_sel = load_word_i[23:16];
         2'd3: byte_sel = load_word_i[31:24];
      endcase
      // Halfword lane ignores addr[0]; misalignment is truncated here.
      half_sel = lane_i[1] ? load_word_i[31:16] : load_word_i[15:0];

      load_data_o = load_word_i;
      case (size_i)
         SIZE_B:  load_data_o = {{24{~unsigned_i & byte_sel[7]}}, byte_sel};
         SIZE_H:  load_data_o = {{16{~unsigned_i & half_sel[15]}}, half_sel};
         default: load_data_o = load_word_i;
      endcase
   end

   // Overlay the store data onto the previously read word.
   always_comb begin
      store_word_o = store_base_i;
      case (size_i)
         SIZE_B: begin
            unique case (lane_i)
               2'd0: store_word_o[7:0]   = store_data_i[7:0];
               2'd1: store_word_o[15:8]  = store_data_i[7:0];
               2'd2: store_word_o[23:16] = store_data_i[7:0];
               2'd3: store_word_o[31:24] = store_data_i[7:0];
            endcase
         end
         SIZE_H: begin
            if (lane_i[1]) store_word_o[31:16] = store_data_i[15:0];
            else           store_word_o[15:0]  = store_data_i[15:0];
         end
         SIZE_W:  store_word_o = store_data_i;
         default: store_word_o = store_base_i;
      endcase
   end

endmodule

// File: rtl/ram_lsu.sv
// Load/store unit in front of a word-addressed RAM with combinational read.
// Sub-word stores are done as read-modify-write. Define RAM_LSU_MISALIGN_TRAP_EN
// to turn misaligned half/word accesses into errors instead of truncating them.
module ram_lsu
   import ram_lsu_pkg::*;
#(
   parameter int unsigned MEM_DEPTH = 4096,
   parameter int unsigned ADDR_W    = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic              req_we_i,
   input  logic [1:0]        req_size_i,
   input  logic              req_unsigned_i,
   input  logic [ADDR_W-1:0] req_addr_i,
   input  logic [WORD_W-1:0] req_wdata_i,
   output logic              rsp_valid_o,
   input  logic              rsp_ready_i,
   output logic [WORD_W-1:0] rsp_rdata_o,
   output logic              rsp_err_o,
   output logic              mem_we_o,
   output logic [31:0]       mem_addr_o,
   output logic [WORD_W-1:0] mem_wdata_o,
   input  logic [WORD_W-1:0] mem_rdata_i
);

   state_e              state_q, state_d;
   logic                we_q, we_d;
   logic [1:0]          size_q, size_d;
   logic                uns_q, uns_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [WORD_W-1:0]   wdata_q, wdata_d;
   logic [WORD_W-1:0]   word_q, word_d;
   logic [WORD_W-1:0]   rdata_q, rdata_d;
   logic                err_q, err_d;

   logic                req_fire;
   logic                range_err;
   logic                misalign_err;
   logic                req_err;
   logic [31:0]         word_addr;
   logic [WORD_W-1:0]   load_data;
   logic [WORD_W-1:0]   store_word;

   assign req_fire  = req_valid_i & req_ready_o;
   assign range_err = req_addr_i[ADDR_W-1:2] >= (ADDR_W-2)'(MEM_DEPTH);

`ifdef RAM_LSU_MISALIGN_TRAP_EN
   assign misalign_err = ((req_size_i == SIZE_H) && req_addr_i[0]) ||
                         ((req_size_i == SIZE_W) && (req_addr_i[1:0] != 2'b00));
`else
   assign misalign_err = 1'b0;
`endif

   assign req_err   = (req_size_i == 2'd3) | range_err | misalign_err;
   assign word_addr = 32'({addr_q[ADDR_W-1:2], 2'b00});

   ram_lsu_lane u_lane (
      .size_i       (size_q),
      .unsigned_i   (uns_q),
      .lane_i       (addr_q[1:0]),
      .load_word_i  (mem_rdata_i),
      .store_base_i (word_q),
      .store_data_i (wdata_q),
      .load_data_o  (load_data),
      .store_word_o (store_word)
   );

   // Next-state: capture in IDLE, sample RAM in READ, hold response until accepted.
   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      size_d  = size_q;
      uns_d   = uns_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      word_d  = word_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      unique case (state_q)
         StIdle: begin
            if (req_fire) begin
               we_d    = req_we_i;
               size_d  = req_size_i;
               uns_d   = req_unsigned_i;
               addr_d  = req_addr_i;
               wdata_d = req_wdata_i;
               rdata_d = '0;
               err_d   = req_err;
               state_d = req_err ? StResp : StRead;
            end
         end
         StRead: begin
            word_d = mem_rdata_i;
            if (we_q) begin
               state_d = StWrite;
            end else begin
               rdata_d = load_data;
               state_d = StResp;
            end
         end
         StWrite: state_d = StResp;
         StResp: begin
            if (rsp_ready_i) begin
               rdata_d = '0;
               err_d   = 1'b0;
               state_d = StIdle;
            end
         end
      endcase
   end

   // Outputs decoded from state; write enable is killed as soon as reset rises.
   always_comb begin
      req_ready_o = (state_q == StIdle);
      rsp_valid_o = (state_q == StResp);
      rsp_rdata_o = rdata_q;
      rsp_err_o   = err_q;
      mem_we_o    = (state_q == StWrite) & ~rst;
      mem_addr_o  = ((state_q == StRead) || (state_q == StWrite)) ? word_addr : 32'd0;
      mem_wdata_o = (state_q == StWrite) ? store_word : '0;
   end

   // State and transaction registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         we_q    <= 1'b0;
         size_q  <= 2'd0;
         uns_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         word_q  <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         size_q  <= size_d;
         uns_q   <= uns_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         word_q  <= word_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: tb/tb_ram_lsu.sv
// Scoreboard bench for ram_lsu with a behavioural 4096x32 RAM.
module tb_ram_lsu;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid_i = 1'b0;
   logic        req_ready_o;
   logic        req_we_i = 1'b0;
   logic [1:0]  req_size_i = 2'd0;
   logic        req_unsigned_i = 1'b0;
   logic [31:0] req_addr_i = 32'd0;
   logic [31:0] req_wdata_i = 32'd0;
   logic        rsp_valid_o;
   logic        rsp_ready_i = 1'b1;
   logic [31:0] rsp_rdata_o;
   logic        rsp_err_o;
   logic        mem_we_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic [31:0] mem_rdata_i;

   bit   [31:0] mem [4096];
   logic [32:0] exp_q [$];
   int          tests = 0;
   int          fails = 0;
   int          we_cnt = 0;
   logic [31:0] last_we_addr = 32'd0;

   ram_lsu dut (
      .clk            (clk),
      .rst            (rst),
      .req_valid_i    (req_valid_i),
      .req_ready_o    (req_ready_o),
      .req_we_i       (req_we_i),
      .req_size_i     (req_size_i),
      .req_unsigned_i (req_unsigned_i),
      .req_addr_i     (req_addr_i),
      .req_wdata_i    (req_wdata_i),
      .rsp_valid_o    (rsp_valid_o),
      .rsp_ready_i    (rsp_ready_i),
      .rsp_rdata_o    (rsp_rdata_o),
      .rsp_err_o      (rsp_err_o),
      .mem_we_o       (mem_we_o),
      .mem_addr_o     (mem_addr_o),
      .mem_wdata_o    (mem_wdata_o),
      .mem_rdata_i    (mem_rdata_i)
   );

   always #5 clk = ~clk;

   assign mem_rdata_i = mem[mem_addr_o[13:2]];

   always @(posedge clk) begin
      if (mem_we_o) mem[mem_addr_o[13:2]] <= mem_wdata_o;
   end

   // Write-pulse counter and response monitor, sampled on the falling edge.
   always @(negedge clk) begin
      logic [32:0] e;
      if (mem_we_o) begin
         we_cnt       = we_cnt + 1;
         last_we_addr = mem_addr_o;
      end
      if (rsp_valid_o && rsp_ready_i) begin
         tests = tests + 1;
         if (exp_q.size() == 0) begin
            fails = fails + 1;
            $display("FAIL rsp_unexpected: got err=%0b rdata=%08h, none expected",
                     rsp_err_o, rsp_rdata_o);
         end else begin
            e = exp_q.pop_front();
            if ({rsp_err_o, rsp_rdata_o} !== e) begin
               fails = fails + 1;
               $display("FAIL rsp_data: got err=%0b rdata=%08h, expected err=%0b rdata=%08h",
                        rsp_err_o, rsp_rdata_o, e[32], e[31:0]);
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      tests = tests + 1;
      if (got !== want) begin
         fails = fails + 1;
         $display("FAIL %s: got %08h, expected %08h", name, got, want);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req_ready"}, 32'(req_ready_o), 32'd1);
      check({tag, "_rsp_valid"}, 32'(rsp_valid_o), 32'd0);
      check({tag, "_rsp_err"},   32'(rsp_err_o),   32'd0);
      check({tag, "_rsp_rdata"}, rsp_rdata_o,      32'd0);
      check({tag, "_mem_we"},    32'(mem_we_o),    32'd0);
      check({tag, "_mem_addr"},  mem_addr_o,       32'd0);
      check({tag, "_mem_wdata"}, mem_wdata_o,      32'd0);
   endtask

   // One request; entered and left shortly after a rising edge with the unit idle.
   task automatic txn(input string name, input logic we, input logic [1:0] size,
                      input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_rdata, input logic exp_err,
                      input int exp_lat, input int hold);
      int          lat;
      int          we0;
      logic [31:0] held;
      check({name, "_ready_in"}, 32'(req_ready_o), 32'd1);
      exp_q.push_back({exp_err, exp_rdata});
      we0            = we_cnt;
      req_we_i       = we;
      req_size_i     = size;
      req_unsigned_i = uns;
      req_addr_i     = addr;
      req_wdata_i    = wdata;
      req_valid_i    = 1'b1;
      rsp_ready_i    = (hold == 0);
      @(posedge clk);
      #1;
      req_valid_i = 1'b0;
      lat = 1;
      while (!rsp_valid_o && lat < 20) begin
         @(posedge clk);
         #1;
         lat = lat + 1;
      end
      check({name, "_latency"}, 32'(lat), 32'(exp_lat));
      if (hold > 0) begin
         held = rsp_rdata_o;
         repeat (hold) begin
            @(posedge clk);
            #1;
            check({name, "_hold_valid"}, 32'(rsp_valid_o), 32'd1);
            check({name, "_hold_rdata"}, rsp_rdata_o, exp_rdata);
            check({name, "_hold_ready"}, 32'(req_ready_o), 32'd0);
         end
         check({name, "_hold_stable"}, rsp_rdata_o, held);
         rsp_ready_i = 1'b1;
      end
      @(posedge clk);
      #1;
      check({name, "_done_valid"}, 32'(rsp_valid_o), 32'd0);
      check({name, "_we_pulses"}, 32'(we_cnt - we0), 32'((we && !exp_err) ? 1 : 0));
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst = 1'b0;
      @(posedge clk);
      #1;

      txn("sw_10", 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 3, 0);
      check("sw_10_addr", last_we_addr, 32'h10);
      txn("lw_10", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2, 0);

      txn("sw_20", 1'b1, 2'd2, 1'b0, 32'h20, 32'h11223344, 32'h0, 1'b0, 3, 0);
      txn("sb_21", 1'b1, 2'd0, 1'b0, 32'h21, 32'h123456AA, 32'h0, 1'b0, 3, 0);
      check("sb_21_addr", last_we_addr, 32'h20);
      txn("lw_20", 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 32'h1122AA44, 1'b0, 2, 0);
      txn("lb_21", 1'b0, 2'd0, 1'b0, 32'h21, 32'h0, 32'hFFFFFFAA, 1'b0, 2, 0);
      txn("lbu_21", 1'b0, 2'd0, 1'b1, 32'h21, 32'h0, 32'h000000AA, 1'b0, 2, 0);
      txn("lb_23", 1'b0, 2'd0, 1'b0, 32'h23, 32'h0, 32'h00000011, 1'b0, 2, 0);

      txn("sh_32", 1'b1, 2'd1, 1'b0, 32'h32, 32'hFFFF8001, 32'h0, 1'b0, 3, 0);
      txn("lw_30", 1'b0, 2'd2, 1'b0, 32'h30, 32'h0, 32'h80010000, 1'b0, 2, 0);
      txn("lh_32", 1'b0, 2'd1, 1'b0, 32'h32, 32'h0, 32'hFFFF8001, 1'b0, 2, 0);
      txn("lhu_32", 1'b0, 2'd1, 1'b1, 32'h32, 32'h0, 32'h00008001, 1'b0, 2, 0);
      txn("lh_30", 1'b0, 2'd1, 1'b0, 32'h30, 32'h0, 32'h00000000, 1'b0, 2, 0);

      txn("lw_4000", 1'b0, 2'd2, 1'b0, 32'h4000, 32'h0, 32'h0, 1'b1, 1, 0);
      txn("lw_3ffc", 1'b0, 2'd2, 1'b0, 32'h3FFC, 32'h0, 32'h0, 1'b0, 2, 0);
      txn("size3", 1'b0, 2'd3, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1, 1, 0);
      txn("sw_4000", 1'b1, 2'd2, 1'b0, 32'h4000, 32'h55555555, 32'h0, 1'b1, 1, 0);
      txn("sb_size3", 1'b1, 2'd3, 1'b0, 32'h10, 32'h55555555, 32'h0, 1'b1, 1, 0);
      txn("lw_10_again", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2, 0);

`ifdef RAM_LSU_MISALIGN_TRAP_EN
      txn("lw_6", 1'b0, 2'd2, 1'b0, 32'h6, 32'h0, 32'h0, 1'b1, 1, 0);
      txn("lw_12", 1'b0, 2'd2, 1'b0, 32'h12, 32'h0, 32'h0, 1'b1, 1, 0);
      txn("lh_13", 1'b0, 2'd1, 1'b0, 32'h13, 32'h0, 32'h0, 1'b1, 1, 0);
      txn("sh_11", 1'b1, 2'd1, 1'b0, 32'h11, 32'h1234, 32'h0, 1'b1, 1, 0);
`else
      txn("lw_12", 1'b0, 2'd2, 1'b0, 32'h12, 32'h0, 32'hDEADBEEF, 1'b0, 2, 0);
      txn("lh_13", 1'b0, 2'd1, 1'b0, 32'h13, 32'h0, 32'hFFFFDEAD, 1'b0, 2, 0);
`endif
      txn("lb_13", 1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 32'hFFFFFFDE, 1'b0, 2, 0);

      // Back-pressure: response held for 5 cycles, then the next request goes straight in.
      txn("bp_lw_20", 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 32'h1122AA44, 1'b0, 2, 5);
      txn("bp_next", 1'b0, 2'd1, 1'b1, 32'h22, 32'h0, 32'h00001122, 1'b0, 2, 0);

      // Reset during WRITE: the pending store must never reach the RAM.
      begin
         int we0;
         we0            = we_cnt;
         req_we_i       = 1'b1;
         req_size_i     = 2'd2;
         req_unsigned_i = 1'b0;
         req_addr_i     = 32'h10;
         req_wdata_i    = 32'hCAFEF00D;
         req_valid_i    = 1'b1;
         @(posedge clk);
         #1;
         req_valid_i = 1'b0;
         @(posedge clk);
         #1;
         check("rst_write_reached", 32'(mem_we_o), 32'd1);
         rst = 1'b1;
         #1;
         check("rst_we_killed", 32'(mem_we_o), 32'd0);
         @(posedge clk);
         #1;
         check_reset_outputs("rst_mid");
         check("rst_no_write", 32'(we_cnt - we0), 32'd0);
         rst = 1'b0;
         @(posedge clk);
         #1;
      end
      txn("post_rst_lw_10", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2, 0);
      txn("post_rst_sb", 1'b1, 2'd0, 1'b0, 32'h12, 32'h7F, 32'h0, 1'b0, 3, 0);
      txn("post_rst_lw", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'hDE7FBEEF, 1'b0, 2, 0);

      repeat (2) @(posedge clk);
      #1;
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/ram_lsu.md
Name: ram_lsu

Overview:
Load/store unit that sits directly upstream of the word-addressed data RAM (4096 x 32, combinational read, registered write on clk, word index = addr[31:2]).
- Accepts byte, halfword and word load/store requests from the core over a valid/ready handshake.
- Performs read-modify-write for sub-word stores.
- Returns sign- or zero-extended load data.
- Flags range errors, and alignment errors when that check is compiled in.

Parameters:
- MEM_DEPTH, 4096: number of 32-bit words in the downstream RAM; used for the range check.
- ADDR_W, 32: width of the request address.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- req_valid_i  in  1  request valid
- req_ready_o  out  1  unit can accept a request
- req_we_i  in  1  1 = store, 0 = load
- req_size_i  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal
- req_unsigned_i  in  1  zero-extend loads when 1
- req_addr_i  in  ADDR_W  byte address
- req_wdata_i  in  32  store data, right-aligned
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  consumer accepts response
- rsp_rdata_o  out  32  extended load data; 0 for stores and errors
- rsp_err_o  out  1  access error
- mem_we_o  out  1  RAM write enable
- mem_addr_o  out  32  RAM byte address, bits [1:0] always 0
- mem_wdata_o  out  32  RAM write word
- mem_rdata_i  in  32  RAM combinational read word

Behaviour:
- Reset (rst=1 at a clk edge): state goes to IDLE.
  - req_ready_o=1, rsp_valid_o=0, rsp_err_o=0, rsp_rdata_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0.
  - Reset mid-operation abandons the transaction. No mem_we_o pulse is issued after reset asserts.
- FSM states: IDLE, READ, WRITE, RESP. Only one request is in flight at a time.
- IDLE:
  - req_ready_o=1. A handshake (req_valid_i & req_ready_o) captures we, size, unsigned, addr and wdata into registers.
  - Error check at capture: err = (size==3) | (addr[ADDR_W-1:2] >= MEM_DEPTH), plus the misalign term when the optional feature is enabled.
  - On err: go to RESP with rsp_err_o=1. No RAM write occurs.
  - Otherwise: go to READ.
- READ:
  - mem_addr_o = {addr[31:2],2'b00}. The unit samples mem_rdata_i into word_q.
  - Load: extract the lane (byte lane = addr[1:0]; half lane = addr[1]), sign- or zero-extend it into rsp_rdata_o, then go to RESP.
  - Store: go to WRITE.
- WRITE:
  - mem_we_o=1 for exactly one cycle.
  - mem_wdata_o = word_q with the addressed lane(s) replaced by wdata[7:0] or wdata[15:0]. A word store replaces the full word.
  - Then go to RESP.
- RESP:
  - rsp_valid_o=1. rsp_rdata_o and rsp_err_o stay stable until rsp_ready_i=1.
  - On rsp_ready_i=1: go to IDLE, drop rsp_valid_o, clear rsp_err_o.
  - req_ready_o=0 in every state except IDLE.
- Latency from the handshake edge to rsp_valid_o:
  - load: 2 cycles
  - store: 3 cycles
  - error: 1 cycle
- Without the optional feature, misaligned half/word accesses use the lane given by addr[1] for halfwords and addr[1:0] forced to 0 for words, with no error.
- Arithmetic: all lane selection is on 32-bit data; the address is never incremented, so no address wrap-around occurs.

Optional Feature:
- Macro: RAM_LSU_MISALIGN_TRAP_EN.
- Defined: size==1 with addr[0]!=0, or size==2 with addr[1:0]!=0, raises rsp_err_o=1 with rdata=0 and no write.
- Undefined: alignment is silently truncated as described in Behaviour, and rsp_err_o reflects only illegal size or out-of-range address.

Decomposition:
- Package ram_lsu_pkg holds:
  - the size enum (SIZE_B=2'd0, SIZE_H=2'd1, SIZE_W=2'd2)
  - the FSM state enum
  - WORD_W=32
- One natural sub-module, ram_lsu_lane: purely combinational.
  - Load side: extract and extend.
  - Store side: merge lanes.

Test Plan:
- sw 0xDEADBEEF @0x10, then lw @0x10 -> one mem_we_o pulse, mem_addr_o=0x10; load rsp_rdata_o=0xDEADBEEF, 2 cycles after the handshake.
- With word @0x20 = 0x11223344: sb 0xAA @0x21, then lw @0x20 -> 0x1122AA44; lb @0x21 -> 0xFFFFFFAA; lbu @0x21 -> 0x000000AA.
- sh 0x8001 @0x32 over 0 -> word 0x80010000; lh @0x32 -> 0xFFFF8001; lhu @0x32 -> 0x00008001.
- Load @0x4000 (word 4096) or size=3 -> rsp_err_o=1, rdata=0, no mem_we_o; with RAM_LSU_MISALIGN_TRAP_EN defined, lw @0x6 -> rsp_err_o=1.
- Back-pressure: hold rsp_ready_i=0 for 5 cycles -> rsp_valid_o and rsp_rdata_o stay stable, req_ready_o=0; the next request is accepted the cycle after rsp_ready_i=1.
- Assert rst in WRITE state -> no mem_we_o that cycle or after; all outputs reach reset values next edge; the next request completes normally.
